veerwolf_board_io: RTL and testbench

//  Board-level I/O conditioner between FPGA pins and veerwolf_core, in the clk_core domain.
//  - Synchronises and debounces NUM_SW switches and NUM_BTN buttons; flags button presses.
//  - Registers NUM_LED LED outputs.
//  - Selects the UART TX pin from NUM_UART sources (CPU, LiteDRAM, ...) and switches only on line idle.

---
 rtl/veerwolf_board_io.sv | 184 ++++++++++++++++++
 tb/tb_veerwolf_board_io.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/veerwolf_board_io.sv
// Board I/O conditioner: synchronised/debounced switches and buttons, registered LEDs,
// glitch-free UART TX source selection. Optional LED PWM dimming: VEERWOLF_LED_PWM_EN.
module veerwolf_board_io #(
  parameter int NUM_SW           = 4,
  parameter int NUM_BTN          = 4,
  parameter int NUM_LED          = 16,
  parameter int NUM_UART         = 2,
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int UART_IDLE_CYCLES = 2170
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SW-1:0]           i_sw,
  input  logic [NUM_BTN-1:0]          i_btn,
  output logic [NUM_SW-1:0]           o_sw_db,
  output logic [NUM_BTN-1:0]          o_btn_db,
  output logic [NUM_BTN-1:0]          o_btn_press,
  input  logic [NUM_LED-1:0]          i_led,
  input  logic [7:0]                  i_led_duty,
  output logic [NUM_LED-1:0]          o_led,
  input  logic [NUM_UART-1:0]         i_uart_tx,
  input  logic [$clog2(NUM_UART)-1:0] i_uart_sel,
  output logic [$clog2(NUM_UART)-1:0] o_uart_sel,
  output logic                        o_uart_tx
);

  localparam int SEL_W  = $clog2(NUM_UART);
  localparam int NUM_IN = NUM_SW + NUM_BTN;
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int IDLE_W = (UART_IDLE_CYCLES > 1) ? $clog2(UART_IDLE_CYCLES + 1) : 1;

  logic [NUM_IN-1:0] pins;
  logic [NUM_IN-1:0] db_vec;

  assign pins = {i_btn, i_sw};

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   db_reg;
      logic                   synced;

      assign synced     = sync_reg[SYNC_STAGES-1];
      assign db_vec[gi] = db_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], pins[gi]};
        end
      end

      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            db_reg <= 1'b0;
          end else begin
            db_reg <= synced;
          end
        end
      end else begin : g_debounce
        logic [CNT_W-1:0] cnt_reg;

        // The output only moves after the synced level has differed for DEBOUNCE_CYCLES cycles.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            db_reg  <= 1'b0;
            cnt_reg <= '0;
          end else if (synced == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_reg  <= synced;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
    end
  endgenerate

  logic [NUM_BTN-1:0] btn_dly_reg;
  logic [NUM_BTN-1:0] press_reg;

  assign o_sw_db     = db_vec[NUM_SW-1:0];
  assign o_btn_db    = db_vec[NUM_IN-1:NUM_SW];
  assign o_btn_press = press_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_dly_reg <= '0;
      press_reg   <= '0;
    end else begin
      btn_dly_reg <= o_btn_db;
      press_reg   <= o_btn_db & ~btn_dly_reg;
    end
  end

  logic [NUM_LED-1:0] led_s1_reg;
  logic [NUM_LED-1:0] led_s2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_s1_reg <= '0;
      led_s2_reg <= '0;
    end else begin
      led_s1_reg <= i_led;
      led_s2_reg <= led_s1_reg;
    end
  end

`ifdef VEERWOLF_LED_PWM_EN
  logic [7:0] pwm_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
    end
  end

  assign o_led = led_s2_reg & {NUM_LED{pwm_cnt_reg < i_led_duty}};
`else
  logic unused_duty;

  assign unused_duty = ^i_led_duty;
  assign o_led       = led_s2_reg;
`endif

  typedef enum logic {ACTIVE, DRAIN} uart_state_t;

  uart_state_t       state_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic              tx_reg;
  logic [IDLE_W-1:0] idle_cnt_reg;
  logic              cur_tx;
  logic              req_valid;

  assign cur_tx     = i_uart_tx[sel_reg];
  assign req_valid  = (32'(i_uart_sel) < NUM_UART);
  assign o_uart_sel = sel_reg;
  assign o_uart_tx  = tx_reg;

  // The source only changes after the current line has been idle long enough to hold no character.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ACTIVE;
      sel_reg      <= '0;
      tx_reg       <= 1'b1;
      idle_cnt_reg <= '0;
    end else begin
      tx_reg <= cur_tx;
      case (state_reg)
        ACTIVE: begin
          idle_cnt_reg <= '0;
          if (req_valid && (i_uart_sel != sel_reg)) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (!req_valid || (i_uart_sel == sel_reg)) begin
            state_reg    <= ACTIVE;
            idle_cnt_reg <= '0;
          end else if (!cur_tx) begin
            idle_cnt_reg <= '0;
          end else if (idle_cnt_reg == IDLE_W'(UART_IDLE_CYCLES - 1)) begin
            sel_reg      <= i_uart_sel;
            idle_cnt_reg <= '0;
            state_reg    <= ACTIVE;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ACTIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_veerwolf_board_io.sv
// Scoreboard bench for veerwolf_board_io: stimulus pushes (cycle, signal, value) expectations,
// a negedge monitor pops and compares them. Second instance has three UART sources.
module tb_veerwolf_board_io;

  localparam int SW_DB = 0, BTN_DB = 1, PRESS = 2, LED = 3, USEL = 4, UTX = 5, USEL3 = 6, UTX3 = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw, btn;
  logic [15:0] led;
  logic [7:0]  duty;
  logic [1:0]  uart_tx;
  logic        uart_sel;
  logic [2:0]  uart_tx3;
  logic [1:0]  uart_sel3;

  logic [3:0]  sw_db, btn_db, btn_press;
  logic [15:0] led_out;
  logic        usel, utx;
  logic [1:0]  usel3;
  logic        utx3;
  logic [3:0]  unused_sw_db3, unused_btn_db3, unused_press3;
  logic [15:0] unused_led3;

  veerwolf_board_io #(
    .NUM_SW(4), .NUM_BTN(4), .NUM_LED(16), .NUM_UART(2),
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .UART_IDLE_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .i_sw(sw), .i_btn(btn),
    .o_sw_db(sw_db), .o_btn_db(btn_db), .o_btn_press(btn_press),
    .i_led(led), .i_led_duty(duty), .o_led(led_out),
    .i_uart_tx(uart_tx), .i_uart_sel(uart_sel), .o_uart_sel(usel), .o_uart_tx(utx)
  );

  veerwolf_board_io #(
    .NUM_SW(4), .NUM_BTN(4), .NUM_LED(16), .NUM_UART(3),
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .UART_IDLE_CYCLES(8)
  ) dut3 (
    .clk(clk), .rst(rst), .i_sw(sw), .i_btn(btn),
    .o_sw_db(unused_sw_db3), .o_btn_db(unused_btn_db3), .o_btn_press(unused_press3),
    .i_led(led), .i_led_duty(duty), .o_led(unused_led3),
    .i_uart_tx(uart_tx3), .i_uart_sel(uart_sel3), .o_uart_sel(usel3), .o_uart_tx(utx3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int id);
    case (id)
      SW_DB:   return 32'(sw_db);
      BTN_DB:  return 32'(btn_db);
      PRESS:   return 32'(btn_press);
      LED:     return 32'(led_out);
      USEL:    return 32'(usel);
      UTX:     return 32'(utx);
      USEL3:   return 32'(usel3);
      default: return 32'(utx3);
    endcase
  endfunction

  function automatic string sig_name(input int id);
    case (id)
      SW_DB:   return "o_sw_db";
      BTN_DB:  return "o_btn_db";
      PRESS:   return "o_btn_press";
      LED:     return "o_led";
      USEL:    return "o_uart_sel";
      UTX:     return "o_uart_tx";
      USEL3:   return "o_uart_sel(3src)";
      default: return "o_uart_tx(3src)";
    endcase
  endfunction

  task automatic push(input int due, input int id, input logic [31:0] e);
    exp_t x;
    x.due = due; x.id = id; x.exp = e;
    sb_q.push_back(x);
  endtask

  // Monitor: compares every expectation due in the current cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due <= cyc) begin
        checks++;
        if (sb_q[i].due < cyc) begin
          errors++;
          $display("FAIL %s missed check due cyc %0d (now %0d)", sig_name(sb_q[i].id), sb_q[i].due, cyc);
        end else if (actual(sb_q[i].id) !== sb_q[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0h expected=%0h", sig_name(sb_q[i].id), cyc,
                   actual(sb_q[i].id), sb_q[i].exp);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string tag);
    int b = 0;
    while (sb_q.size() != 0 && b < 300) begin
      @(posedge clk);
      b++;
    end
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s scoreboard not drained: %0d pending, expected 0", tag, sb_q.size());
      sb_q.delete();
    end
    $display("step %s done at cyc %0d, checks=%0d errors=%0d", tag, cyc, checks, errors);
  endtask

  task automatic push_reset_vals(input int due);
    push(due, SW_DB, 0); push(due, BTN_DB, 0); push(due, PRESS, 0); push(due, LED, 0);
    push(due, USEL, 0);  push(due, UTX, 1);    push(due, USEL3, 0); push(due, UTX3, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [9:0] frame;
    logic v0;
    logic sel_exp;
    rst = 1'b1; sw = '0; btn = '0; led = '0; duty = 8'd64;
    uart_tx = 2'b11; uart_sel = 1'b0; uart_tx3 = 3'b111; uart_sel3 = 2'd0;

    // Reset state
    step(1);
    push_reset_vals(cyc);
    step(2);
    rst = 1'b0;
    wait_empty("reset");

    // Clean switch edge: latency SYNC_STAGES + DEBOUNCE_CYCLES = 6
    c = cyc; sw = 4'b0001;
    push(c + 5, SW_DB, 4'b0000);
    push(c + 6, SW_DB, 4'b0001);
    wait_empty("sw_edge");

    // 3-cycle glitch on sw[1] must never appear
    c = cyc; sw = 4'b0011;
    for (int k = 1; k <= 12; k++) push(c + k, SW_DB, 4'b0001);
    step(3);
    sw = 4'b0001;
    wait_empty("sw_glitch");

    // Bouncing button: one press pulse, 1 cycle wide
    c = cyc;
    for (int k = 1; k <= 10; k++) push(c + k, PRESS, 4'b0000);
    push(c + 11, PRESS, 4'b0100);
    for (int k = 12; k <= 16; k++) push(c + k, PRESS, 4'b0000);
    push(c + 9, BTN_DB, 4'b0000);
    push(c + 10, BTN_DB, 4'b0100);
    btn = 4'b0100; step(1);
    btn = 4'b0000; step(1);
    btn = 4'b0100; step(1);
    btn = 4'b0000; step(1);
    btn = 4'b0100;
    wait_empty("btn_bounce");

    // Release: no press pulse
    c = cyc; btn = 4'b0000;
    for (int k = 1; k <= 12; k++) push(c + k, PRESS, 4'b0000);
    push(c + 5, BTN_DB, 4'b0100);
    push(c + 6, BTN_DB, 4'b0000);
    wait_empty("btn_release");

    // Switch request during a 0x55 frame (3 cycles/bit): switch 8 high cycles after stop bit starts
    frame = {1'b1, 8'h55, 1'b0};
    c = cyc; uart_sel = 1'b1;
    for (int t = 0; t < 45; t++) begin
      v0 = (t / 3 < 10) ? frame[t / 3] : 1'b1;
      uart_tx = {1'b0, v0};
      sel_exp = (cyc < c + 35) ? 1'b0 : 1'b1;
      push(cyc, USEL, 32'(sel_exp));
      push(cyc + 1, UTX, sel_exp ? 32'd0 : 32'(v0));
      step(1);
    end
    wait_empty("uart_drain");

    // Back to source 0 from idle source 1: switch visible 9 cycles after request
    c = cyc; uart_tx = 2'b11; uart_sel = 1'b0;
    push(c + 8, USEL, 1);
    push(c + 9, USEL, 0);
    wait_empty("uart_back");

    // 0->1->0 within the drain window: no switch
    c = cyc; uart_sel = 1'b1;
    for (int k = 0; k <= 20; k++) push(c + k, USEL, 0);
    step(3);
    uart_sel = 1'b0;
    wait_empty("uart_abort");

    // Out-of-range request on the 3-source instance is ignored
    c = cyc; uart_sel3 = 2'd3; uart_tx3 = 3'b110;
    for (int k = 1; k <= 15; k++) begin
      push(c + k, USEL3, 0);
      push(c + k, UTX3, 0);
    end
    wait_empty("uart_oor");
    uart_sel3 = 2'd0; uart_tx3 = 3'b111;

`ifdef VEERWOLF_LED_PWM_EN
    begin
      int hi = 0;
      led = 16'hA5A5; duty = 8'd64;
      step(3);
      for (int k = 0; k < 256; k++) begin
        @(negedge clk);
        if (led_out[0]) hi++;
        checks++;
        if ((led_out & ~16'hA5A5) != 16'h0) begin
          errors++;
          $display("FAIL led_mask got=%0h expected subset of a5a5", led_out);
        end
      end
      checks++;
      if (hi != 64) begin
        errors++;
        $display("FAIL led_pwm_duty high=%0d expected=64", hi);
      end
      $display("step led_pwm high cycles=%0d", hi);
      #1;
    end
`else
    c = cyc; led = 16'hA5A5;
    push(c + 1, LED, 16'h0000);
    push(c + 2, LED, 16'hA5A5);
    wait_empty("led");
`endif

    // Reset mid-DRAIN and mid-debounce
    led = 16'hA5A5; sw = 4'b0101; uart_tx = 2'b10; uart_sel = 1'b1;
    step(3);
    @(posedge clk);
    #2 rst = 1'b1;
    push_reset_vals(cyc);
    step(1);
    push_reset_vals(cyc);
    wait_empty("reset_mid");
    rst = 1'b0; uart_sel = 1'b0; sw = 4'b0000; led = 16'h0000;
    for (int t = 0; t < 6; t++) begin
      v0 = (t == 1 || t == 2 || t == 4) ? 1'b1 : 1'b0;
      uart_tx = {1'b0, v0};
      push(cyc, USEL, 0);
      push(cyc + 1, UTX, 32'(v0));
      step(1);
    end
    uart_tx = 2'b11;
    wait_empty("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
